// File: rtl/traffic_light_fsm_pkg.sv
// Shared types, default timings and constant helpers for the highway/country traffic controller.
package traffic_pkg;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned COL_W = 3;

   localparam int unsigned T_HG_DEF = 25;
   localparam int unsigned T_HY_DEF = 3;
   localparam int unsigned T_CG_DEF = 10;
   localparam int unsigned T_CY_DEF = 3;

   typedef enum logic [COL_W-1:0] {
      COL_RED    = 3'd1,
      COL_YELLOW = 3'd2,
      COL_GREEN  = 3'd3
   } color_e;

   typedef enum logic [1:0] {
      ST_HG,
      ST_HY,
      ST_CG,
      ST_CY
   } state_e;

   // Binary 0..99 to packed two-digit BCD {tens, units}
   function automatic logic [CNT_W-1:0] to_bcd(input int unsigned v);
      int unsigned tens;
      int unsigned units;
      tens  = v / 10;
      units = v % 10;
      return {tens[3:0], units[3:0]};
   endfunction

   function automatic color_e h_color(input state_e s);
      color_e c;
      c = COL_RED;
      case (s)
         ST_HG:   c = COL_GREEN;
         ST_HY:   c = COL_YELLOW;
         default: c = COL_RED;
      endcase
      return c;
   endfunction

   function automatic color_e cr_color(input state_e s);
      color_e c;
      c = COL_RED;
      case (s)
         ST_CG:   c = COL_GREEN;
         ST_CY:   c = COL_YELLOW;
         default: c = COL_RED;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Bundle of controller-to-display-stage signals; master is the controller side, slave the consumer side.
interface traffic_light_fsm_if;
   import traffic_pkg::*;

   logic             tick_1hz;
   logic             sensor;
   logic [CNT_W-1:0] count_h;
   logic [CNT_W-1:0] count_cr;
   logic [COL_W-1:0] color_h;
   logic [COL_W-1:0] color_cr;

   modport master (
      input  tick_1hz, sensor,
      output count_h, count_cr, color_h, color_cr
   );

   modport slave (
      output tick_1hz, sensor,
      input  count_h, count_cr, color_h, color_cr
   );

endinterface

// File: rtl/traffic_light_fsm_bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load (priority) and decrement enable.
module bcd_down_counter
   import traffic_pkg::*;
(
   input  logic             clk_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i) begin
         if (count_q[3:0] == 4'd0) begin
            count_d = {count_q[7:4] - 4'd1, 4'd9};
         end else begin
            count_d = {count_q[7:4], count_q[3:0] - 4'd1};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Highway/country-road traffic light controller: 4-phase FSM advanced by a 1 Hz tick,
// with BCD countdowns for the seven-segment stage and sensor-gated highway green extension.
module traffic_light_fsm
   import traffic_pkg::*;
#(
   parameter int unsigned T_HG = T_HG_DEF,
   parameter int unsigned T_HY = T_HY_DEF,
   parameter int unsigned T_CG = T_CG_DEF,
   parameter int unsigned T_CY = T_CY_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_1hz,
   input  logic             sensor,
   output logic [CNT_W-1:0] count_h,
   output logic [CNT_W-1:0] count_cr,
   output logic [COL_W-1:0] color_h,
   output logic [COL_W-1:0] color_cr
);

   if (T_HG < 1 || T_HG > 99 || T_HY < 1 || T_HY > 99 ||
       T_CG < 1 || T_CG > 99 || T_CY < 1 || T_CY > 99 ||
       T_HG + T_HY > 99 || T_CG + T_CY > 99) begin : g_bad_params
      $error("traffic_light_fsm: timing parameters out of range");
   end

   localparam logic [CNT_W-1:0] BCD_HG    = to_bcd(T_HG);
   localparam logic [CNT_W-1:0] BCD_HG_HY = to_bcd(T_HG + T_HY);
   localparam logic [CNT_W-1:0] BCD_HY    = to_bcd(T_HY);
   localparam logic [CNT_W-1:0] BCD_CG    = to_bcd(T_CG);
   localparam logic [CNT_W-1:0] BCD_CG_CY = to_bcd(T_CG + T_CY);
   localparam logic [CNT_W-1:0] BCD_CY    = to_bcd(T_CY);
   localparam logic [CNT_W-1:0] BCD_ONE   = 8'h01;

   state_e           state_q;
   state_e           state_d;
   color_e           color_h_q;
   color_e           color_cr_q;
   logic             load;
   logic             dec;
   logic [CNT_W-1:0] ld_h;
   logic [CNT_W-1:0] ld_cr;
   logic [CNT_W-1:0] cnt_h;
   logic [CNT_W-1:0] cnt_cr;

   // The counter that times each phase is the one facing the lit green/yellow;
   // the other one shows the time until its own road turns green.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      dec     = 1'b0;
      ld_h    = '0;
      ld_cr   = '0;
      if (rst) begin
         state_d = ST_HG;
         load    = 1'b1;
         ld_h    = BCD_HG;
         ld_cr   = BCD_HG_HY;
      end else if (tick_1hz) begin
         case (state_q)
            ST_HG: begin
               if (cnt_h != BCD_ONE) begin
                  dec = 1'b1;
               end else if (sensor) begin
                  state_d = ST_HY;
                  load    = 1'b1;
                  ld_h    = BCD_HY;
                  ld_cr   = BCD_HY;
               end
            end
            ST_HY: begin
               if (cnt_h != BCD_ONE) begin
                  dec = 1'b1;
               end else begin
                  state_d = ST_CG;
                  load    = 1'b1;
                  ld_h    = BCD_CG_CY;
                  ld_cr   = BCD_CG;
               end
            end
            ST_CG: begin
               if (cnt_cr != BCD_ONE) begin
                  dec = 1'b1;
               end else begin
                  state_d = ST_CY;
                  load    = 1'b1;
                  ld_h    = BCD_CY;
                  ld_cr   = BCD_CY;
               end
            end
            ST_CY: begin
               if (cnt_cr != BCD_ONE) begin
                  dec = 1'b1;
               end else begin
                  state_d = ST_HG;
                  load    = 1'b1;
                  ld_h    = BCD_HG;
                  ld_cr   = BCD_HG_HY;
               end
            end
            default: state_d = ST_HG;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_HG;
         color_h_q  <= COL_GREEN;
         color_cr_q <= COL_RED;
      end else begin
         state_q    <= state_d;
         color_h_q  <= h_color(state_d);
         color_cr_q <= cr_color(state_d);
      end
   end

   bcd_down_counter u_cnt_h (
      .clk_i      (clk),
      .load_i     (load),
      .load_val_i (ld_h),
      .dec_i      (dec),
      .count_o    (cnt_h)
   );

   bcd_down_counter u_cnt_cr (
      .clk_i      (clk),
      .load_i     (load),
      .load_val_i (ld_cr),
      .dec_i      (dec),
      .count_o    (cnt_cr)
   );

   assign count_h  = cnt_h;
   assign count_cr = cnt_cr;
   assign color_h  = color_h_q;
   assign color_cr = color_cr_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench: three controllers with different timings share stimulus and are
// compared every cycle against a phase/remaining-seconds model, plus literal spot checks.
module tb_traffic_light_fsm;
   import traffic_pkg::*;

   logic clk;
   logic rst;
   logic tick;
   logic sensor;

   int unsigned passed = 0;
   int unsigned total  = 0;

   traffic_light_fsm_if bus0 ();
   traffic_light_fsm_if bus1 ();
   traffic_light_fsm_if bus2 ();

   assign bus0.tick_1hz = tick;
   assign bus1.tick_1hz = tick;
   assign bus2.tick_1hz = tick;
   assign bus0.sensor   = sensor;
   assign bus1.sensor   = sensor;
   assign bus2.sensor   = sensor;

   traffic_light_fsm #(.T_HG(25), .T_HY(3), .T_CG(10), .T_CY(3)) u_dut0 (
      .clk(clk), .rst(rst), .tick_1hz(bus0.tick_1hz), .sensor(bus0.sensor),
      .count_h(bus0.count_h), .count_cr(bus0.count_cr),
      .color_h(bus0.color_h), .color_cr(bus0.color_cr));

   traffic_light_fsm #(.T_HG(3), .T_HY(3), .T_CG(10), .T_CY(3)) u_dut1 (
      .clk(clk), .rst(rst), .tick_1hz(bus1.tick_1hz), .sensor(bus1.sensor),
      .count_h(bus1.count_h), .count_cr(bus1.count_cr),
      .color_h(bus1.color_h), .color_cr(bus1.color_cr));

   traffic_light_fsm #(.T_HG(3), .T_HY(2), .T_CG(4), .T_CY(2)) u_dut2 (
      .clk(clk), .rst(rst), .tick_1hz(bus2.tick_1hz), .sensor(bus2.sensor),
      .count_h(bus2.count_h), .count_cr(bus2.count_cr),
      .color_h(bus2.color_h), .color_cr(bus2.color_cr));

   logic [7:0] o_h   [3];
   logic [7:0] o_cr  [3];
   logic [2:0] o_ch  [3];
   logic [2:0] o_ccr [3];

   assign o_h[0] = bus0.count_h;  assign o_cr[0] = bus0.count_cr;
   assign o_h[1] = bus1.count_h;  assign o_cr[1] = bus1.count_cr;
   assign o_h[2] = bus2.count_h;  assign o_cr[2] = bus2.count_cr;
   assign o_ch[0] = bus0.color_h; assign o_ccr[0] = bus0.color_cr;
   assign o_ch[1] = bus1.color_h; assign o_ccr[1] = bus1.color_cr;
   assign o_ch[2] = bus2.color_h; assign o_ccr[2] = bus2.color_cr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: phase 0..3 = HG,HY,CG,CY and seconds left in the phase
   int unsigned m_thg [3] = '{25, 3, 3};
   int unsigned m_thy [3] = '{3, 3, 2};
   int unsigned m_tcg [3] = '{10, 10, 4};
   int unsigned m_tcy [3] = '{3, 3, 2};
   int unsigned m_ph  [3];
   int unsigned m_rem [3];
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_ph[i]  = 0;
            m_rem[i] = m_thg[i];
         end
         m_valid = 1'b1;
      end else if (tick) begin
         for (int i = 0; i < 3; i++) begin
            if (m_rem[i] > 1) begin
               m_rem[i] = m_rem[i] - 1;
            end else if (m_ph[i] == 0) begin
               if (sensor) begin
                  m_ph[i] = 1; m_rem[i] = m_thy[i];
               end
            end else if (m_ph[i] == 1) begin
               m_ph[i] = 2; m_rem[i] = m_tcg[i];
            end else if (m_ph[i] == 2) begin
               m_ph[i] = 3; m_rem[i] = m_tcy[i];
            end else begin
               m_ph[i] = 0; m_rem[i] = m_thg[i];
            end
         end
      end
   end

   function automatic int unsigned bcd(input int unsigned v);
      return (v / 10) * 16 + (v % 10);
   endfunction

   function automatic int unsigned exp_h(input int i);
      return (m_ph[i] == 2) ? bcd(m_rem[i] + m_tcy[i]) : bcd(m_rem[i]);
   endfunction

   function automatic int unsigned exp_cr(input int i);
      return (m_ph[i] == 0) ? bcd(m_rem[i] + m_thy[i]) : bcd(m_rem[i]);
   endfunction

   function automatic int unsigned exp_ch(input int i);
      return (m_ph[i] == 0) ? 3 : (m_ph[i] == 1) ? 2 : 1;
   endfunction

   function automatic int unsigned exp_ccr(input int i);
      return (m_ph[i] == 2) ? 3 : (m_ph[i] == 3) ? 2 : 1;
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("model dut%0d count_h", i),  o_h[i],   exp_h(i));
            check($sformatf("model dut%0d count_cr", i), o_cr[i],  exp_cr(i));
            check($sformatf("model dut%0d color_h", i),  o_ch[i],  exp_ch(i));
            check($sformatf("model dut%0d color_cr", i), o_ccr[i], exp_ccr(i));
         end
      end
   end

   task automatic lit(input string tag, input int i, input logic [7:0] h, input logic [7:0] cr,
                      input logic [2:0] ch, input logic [2:0] ccr);
      check($sformatf("%s dut%0d count_h", tag, i),  o_h[i],   h);
      check($sformatf("%s dut%0d count_cr", tag, i), o_cr[i],  cr);
      check($sformatf("%s dut%0d color_h", tag, i),  o_ch[i],  ch);
      check($sformatf("%s dut%0d color_cr", tag, i), o_ccr[i], ccr);
   endtask

   task automatic cycle(input bit r, input bit t, input bit s);
      rst = r; tick = t; sensor = s;
      @(negedge clk);
   endtask

   task automatic ticks(input int n, input bit s);
      for (int k = 0; k < n; k++) begin
         cycle(1'b0, 1'b1, s);
         cycle(1'b0, 1'b0, s);
      end
   endtask

   logic [7:0] fc_h   [11] = '{8'h02, 8'h01, 8'h02, 8'h01, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h03};
   logic [7:0] fc_cr  [11] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h04, 8'h03, 8'h02, 8'h01, 8'h02, 8'h01, 8'h05};
   logic [2:0] fc_ch  [11] = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3};
   logic [2:0] fc_ccr [11] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1};

   initial begin
      rst = 1'b0; tick = 1'b0; sensor = 1'b0;
      @(negedge clk);

      cycle(1'b1, 1'b1, 1'b0);
      lit("reset", 0, 8'h25, 8'h28, 3'd3, 3'd1);
      lit("reset", 1, 8'h03, 8'h06, 3'd3, 3'd1);
      lit("reset", 2, 8'h03, 8'h05, 3'd3, 3'd1);

      ticks(10, 1'b0);
      lit("extend", 1, 8'h01, 8'h04, 3'd3, 3'd1);
      ticks(5, 1'b0);
      lit("borrow15", 0, 8'h10, 8'h13, 3'd3, 3'd1);
      ticks(1, 1'b0);
      lit("borrow16", 0, 8'h09, 8'h12, 3'd3, 3'd1);

      for (int k = 0; k < 1000; k++) cycle(1'b0, 1'b0, k[0]);
      lit("hold", 0, 8'h09, 8'h12, 3'd3, 3'd1);
      lit("hold", 1, 8'h01, 8'h04, 3'd3, 3'd1);

      cycle(1'b0, 1'b1, 1'b1);
      lit("sensor", 1, 8'h03, 8'h03, 3'd2, 3'd1);
      lit("sensor", 0, 8'h08, 8'h11, 3'd3, 3'd1);
      cycle(1'b0, 1'b0, 1'b0);

      cycle(1'b1, 1'b0, 1'b1);
      lit("reset2", 2, 8'h03, 8'h05, 3'd3, 3'd1);
      for (int k = 0; k < 11; k++) begin
         cycle(1'b0, 1'b1, 1'b1);
         lit($sformatf("cycle%0d", k + 1), 2, fc_h[k], fc_cr[k], fc_ch[k], fc_ccr[k]);
         cycle(1'b0, 1'b0, 1'b1);
         cycle(1'b0, 1'b0, 1'b0);
      end

      cycle(1'b1, 1'b1, 1'b0);
      ticks(7, 1'b1);
      lit("cg_mid", 2, 8'h04, 8'h02, 3'd1, 3'd3);
      cycle(1'b1, 1'b1, 1'($urandom_range(1)));
      lit("midreset", 2, 8'h03, 8'h05, 3'd3, 3'd1);
      lit("midreset", 0, 8'h25, 8'h28, 3'd3, 3'd1);

      ticks(4, 1'b1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
